// File: rtl/apb_mq_pkg.sv
// Shared types and width helpers for the queued APB master.
package apb_mq_pkg;

    // Bridge control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } state_t;

    // Widths of the default bridge configuration.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_STRB_W = CMD_DATA_W / 8;

    // One queued user command (default configuration widths). The top
    // builds the same layout at its own parameter widths.
    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0] strb;
    } cmd_t;

    // Width of the slave index field; never narrower than one bit.
    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Width of the wait-state counter: holds values up to TIMEOUT-1.
    function automatic int cnt_width(input int t);
        if (t <= 2) begin
            return 1;
        end else begin
            return $clog2(t);
        end
    endfunction

    // FIFO pointer width without the wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/apb_master_queued_if.sv
// Command, response and APB bus signals of the queued APB master.
interface apb_master_queued_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [STRB_W-1:0]     cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_error;

    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [STRB_W-1:0]     PSTRB;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a counter. ready is registered !full.
module apb_cmd_fifo
    import apb_mq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cmd_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   ready
);
    localparam int AW = ptr_width(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] wr_ptr_nxt_s;
    logic [AW:0] rd_ptr_nxt_s;
    logic        full_s;
    logic        full_nxt_s;
    logic        do_push_s;
    logic        do_pop_s;
    logic        ready_r;
    entry_t      mem_r [DEPTH];

    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push_s = push && !full_s;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign ready     = ready_r;

    // Next pointer values and the full flag they imply.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (do_push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        full_nxt_s = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                     (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    end

    // Pointer and ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            ready_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            ready_r  <= !full_nxt_s;
        end
    end

    // Entry storage, written at the write pointer on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/apb_master_queued.sv
// Queued APB4 master: buffers commands, issues them one at a time as
// SETUP/ACCESS transfers to a decoded slave and returns one response each.
module apb_master_queued
    import apb_mq_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_queued_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = sel_width(NUM_SLAVES);
    localparam int CNT_W  = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    // Command layout of cmd_t at this instance's widths.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } bus_cmd_t;

    state_t                state_r, state_nxt_s;
    bus_cmd_t              push_cmd_s;
    bus_cmd_t              head_s;
    logic                  fifo_empty_s;
    logic                  fifo_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic [SEL_W-1:0]      idx_s;
    logic                  idx_ok_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic [NUM_SLAVES-1:0] psel_r, psel_nxt_s;
    logic                  penable_r, penable_nxt_s;
    logic                  pwrite_r, pwrite_nxt_s;
    logic [ADDR_W-1:0]     paddr_r, paddr_nxt_s;
    logic [DATA_W-1:0]     pwdata_r, pwdata_nxt_s;
    logic [STRB_W-1:0]     pstrb_r, pstrb_nxt_s;
    logic                  rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_W-1:0]     rsp_rdata_r, rsp_rdata_nxt_s;
    logic                  rsp_error_r, rsp_error_nxt_s;

    assign push_s           = bus.cmd_valid && fifo_ready_s;
    assign push_cmd_s.write = bus.cmd_write;
    assign push_cmd_s.addr  = bus.cmd_addr;
    assign push_cmd_s.wdata = bus.cmd_wdata;
    assign push_cmd_s.strb  = bus.cmd_strb;

    apb_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (bus_cmd_t)
    ) u_fifo (
        .clk       (PCLK),
        .rst       (PRESET),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (fifo_empty_s),
        .ready     (fifo_ready_s)
    );

    // Slave index decode of the command at the FIFO head.
    assign idx_s    = head_s.addr[SLV_LSB +: SEL_W];
    assign idx_ok_s = (int'(idx_s) < NUM_SLAVES);

    // Next state, next APB outputs and next response contents.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        psel_nxt_s      = psel_r;
        penable_nxt_s   = penable_r;
        pwrite_nxt_s    = pwrite_r;
        paddr_nxt_s     = paddr_r;
        pwdata_nxt_s    = pwdata_r;
        pstrb_nxt_s     = pstrb_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_error_nxt_s = rsp_error_r;
        pop_s           = 1'b0;

        // A consumed response frees the slot; otherwise it is held.
        if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_nxt_s = 1'b0;
            rsp_rdata_nxt_s = '0;
            rsp_error_nxt_s = 1'b0;
        end else begin
            rsp_valid_nxt_s = rsp_valid_r;
        end

        case (state_r)
            IDLE: begin
                // Only one response can be outstanding, so wait for a free slot.
                if (!fifo_empty_s && !rsp_valid_r) begin
                    pop_s        = 1'b1;
                    cnt_nxt_s    = '0;
                    pwrite_nxt_s = head_s.write;
                    paddr_nxt_s  = head_s.addr;
                    pwdata_nxt_s = head_s.wdata;
                    pstrb_nxt_s  = head_s.write ? head_s.strb : '0;
                    if (idx_ok_s) begin
                        psel_nxt_s  = NUM_SLAVES'(1'b1) << idx_s;
                        state_nxt_s = SETUP;
                    end else begin
                        psel_nxt_s  = '0;
                        state_nxt_s = DECERR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                penable_nxt_s = 1'b1;
                state_nxt_s   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = pwrite_r ? '0 : bus.PRDATA;
                    rsp_error_nxt_s = bus.PSLVERR;
                    psel_nxt_s      = '0;
                    penable_nxt_s   = 1'b0;
                    state_nxt_s     = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                    // Slave never answered: abandon the transfer.
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = '0;
                    rsp_error_nxt_s = 1'b1;
                    psel_nxt_s      = '0;
                    penable_nxt_s   = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DECERR: begin
                rsp_valid_nxt_s = 1'b1;
                rsp_rdata_nxt_s = '0;
                rsp_error_nxt_s = 1'b1;
                state_nxt_s     = IDLE;
            end
            default: begin
                psel_nxt_s    = '0;
                penable_nxt_s = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // State, counter, APB output and response registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            psel_r      <= '0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
            pstrb_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            psel_r      <= psel_nxt_s;
            penable_r   <= penable_nxt_s;
            pwrite_r    <= pwrite_nxt_s;
            paddr_r     <= paddr_nxt_s;
            pwdata_r    <= pwdata_nxt_s;
            pstrb_r     <= pstrb_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_error_r <= rsp_error_nxt_s;
        end
    end

    assign bus.cmd_ready = fifo_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_error = rsp_error_r;
    assign bus.PSEL      = psel_r;
    assign bus.PENABLE   = penable_r;
    assign bus.PWRITE    = pwrite_r;
    assign bus.PADDR     = paddr_r;
    assign bus.PWDATA    = pwdata_r;
    assign bus.PSTRB     = pstrb_r;

endmodule

// File: tb/tb_apb_master_queued.sv
// Directed bench for apb_master_queued: latency, wait states, queueing,
// timeout, decode error, slave error and reset mid-transfer.
module tb_apb_master_queued;

    logic PCLK = 1'b0;
    logic PRESET;
    int   checks = 0;
    int   errors = 0;
    logic        auto_prdata;
    logic [31:0] prdata_val;

    always #5 PCLK = ~PCLK;

    apb_master_queued_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus ();
    apb_master_queued_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus3 ();

    apb_master_queued #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .NUM_SLAVES(4),
                        .SLV_LSB(12), .TIMEOUT(16))
        dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

    apb_master_queued #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .NUM_SLAVES(3),
                        .SLV_LSB(12), .TIMEOUT(16))
        dut3 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus3));

    // Slave read data: either a fixed value or a tag derived from the address.
    always_comb bus.PRDATA = auto_prdata ? {16'hC0DE, bus.PADDR[15:0]} : prdata_val;

    task automatic step;
        @(posedge PCLK);
        #1;
    endtask

    // Offer one command and wait (bounded) for it to be accepted.
    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output bit ok);
        logic rdy;
        ok = 1'b0;
        bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_strb = s;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.cmd_ready;
            step();
            if (rdy) begin ok = 1'b1; break; end
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Act as the slave: hold PREADY low for w ACCESS cycles, then raise it;
    // return the number of ACCESS cycles seen before rsp_valid.
    task automatic wait_rsp(input int w, output int acc, output bit ok);
        ok = 1'b0; acc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.rsp_valid) begin ok = 1'b1; break; end
            if (bus.PENABLE) begin
                acc++;
                bus.PREADY = (acc > w) ? 1'b1 : 1'b0;
            end else begin
                bus.PREADY = 1'b0;
            end
        end
        bus.PREADY = 1'b0;
    endtask

    task automatic test_reset;
        PRESET = 1'b1;
        step(); step();
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.PSEL !== 4'b0000) begin errors++; $display("FAIL reset_psel: got %b expected 0000", bus.PSEL); end
        checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b expected 0", bus.PENABLE); end
        checks++; if (bus.PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h expected 0", bus.PADDR); end
        PRESET = 1'b0;
        step();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_write_latency;
        bit ok;
        bus.rsp_ready = 1'b1; bus.PREADY = 1'b1;
        push_cmd(1'b1, 32'h0000_0000, 32'h0000_00A5, 4'hF, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_accept: got 0 expected 1"); end
        checks++; if (bus.PSEL !== 4'b0000) begin errors++; $display("FAIL wr_c1_psel: got %b expected 0000", bus.PSEL); end
        step();
        checks++; if (bus.PSEL !== 4'b0001) begin errors++; $display("FAIL wr_c2_psel: got %b expected 0001", bus.PSEL); end
        checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_c2_penable: got %b expected 0", bus.PENABLE); end
        checks++; if ({bus.PWRITE, bus.PWDATA, bus.PSTRB} !== {1'b1, 32'h0000_00A5, 4'hF}) begin
            errors++; $display("FAIL wr_c2_fields: got %b %h %h expected 1 000000a5 f", bus.PWRITE, bus.PWDATA, bus.PSTRB); end
        step();
        checks++; if ({bus.PSEL, bus.PENABLE} !== 5'b0001_1) begin errors++; $display("FAIL wr_c3_access: got %b %b expected 0001 1", bus.PSEL, bus.PENABLE); end
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_error} !== 2'b10) begin errors++; $display("FAIL wr_c4_rsp: got %b%b expected 10", bus.rsp_valid, bus.rsp_error); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_c4_rdata: got %h expected 0", bus.rsp_rdata); end
        checks++; if ({bus.PSEL, bus.PENABLE} !== 5'b0) begin errors++; $display("FAIL wr_c4_idle: got %b %b expected 0000 0", bus.PSEL, bus.PENABLE); end
        bus.PREADY = 1'b0;
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_clear: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_read_wait;
        bit ok; int acc;
        auto_prdata = 1'b0; prdata_val = 32'h0000_0005;
        push_cmd(1'b0, 32'h0000_1008, 32'hFFFF_FFFF, 4'hF, ok);
        step();
        checks++; if (bus.PSEL !== 4'b0010) begin errors++; $display("FAIL rd_psel: got %b expected 0010", bus.PSEL); end
        checks++; if ({bus.PWRITE, bus.PSTRB, bus.PADDR} !== {1'b0, 4'h0, 32'h0000_1008}) begin
            errors++; $display("FAIL rd_fields: got %b %h %h expected 0 0 00001008", bus.PWRITE, bus.PSTRB, bus.PADDR); end
        wait_rsp(3, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_rsp_timeout: got none expected rsp_valid"); end
        checks++; if (acc !== 4) begin errors++; $display("FAIL rd_access_cycles: got %0d expected 4", acc); end
        checks++; if ({bus.rsp_rdata, bus.rsp_error} !== {32'h0000_0005, 1'b0}) begin
            errors++; $display("FAIL rd_rsp: got %h %b expected 00000005 0", bus.rsp_rdata, bus.rsp_error); end
        step();
    endtask

    task automatic test_timeout;
        bit ok; int acc;
        auto_prdata = 1'b1;
        push_cmd(1'b0, 32'h0000_2010, 32'h0, 4'h0, ok);
        wait_rsp(1000, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_rsp_missing: got none expected rsp_valid"); end
        checks++; if (acc !== 16) begin errors++; $display("FAIL to_access_cycles: got %0d expected 16", acc); end
        checks++; if ({bus.PSEL, bus.PENABLE} !== 5'b0) begin errors++; $display("FAIL to_psel: got %b %b expected 0000 0", bus.PSEL, bus.PENABLE); end
        checks++; if ({bus.rsp_error, bus.rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL to_rsp: got %b %h expected 1 00000000", bus.rsp_error, bus.rsp_rdata); end
        step();
    endtask

    task automatic test_slverr;
        bit ok; int acc;
        bus.PSLVERR = 1'b1;
        push_cmd(1'b1, 32'h0000_3004, 32'h0000_1234, 4'h3, ok);
        step();
        checks++; if (bus.PSEL !== 4'b1000) begin errors++; $display("FAIL se_psel: got %b expected 1000", bus.PSEL); end
        checks++; if (bus.PSTRB !== 4'h3) begin errors++; $display("FAIL se_pstrb: got %h expected 3", bus.PSTRB); end
        wait_rsp(0, acc, ok);
        checks++; if (!ok || acc !== 1) begin errors++; $display("FAIL se_access: got ok=%0d cycles=%0d expected ok=1 cycles=1", ok, acc); end
        checks++; if ({bus.rsp_error, bus.rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL se_rsp: got %b %h expected 1 00000000", bus.rsp_error, bus.rsp_rdata); end
        bus.PSLVERR = 1'b0;
        step();
    endtask

    task automatic test_decode_err;
        bit seen_psel; bit got; int n;
        seen_psel = 1'b0; got = 1'b0; n = 0;
        bus3.cmd_write = 1'b0; bus3.cmd_addr = 32'h0000_3000; bus3.cmd_strb = 4'hF;
        bus3.cmd_valid = 1'b1;
        step();
        bus3.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (bus3.PSEL !== 3'b000) seen_psel = 1'b1;
            if (bus3.rsp_valid) begin got = 1'b1; break; end
        end
        checks++; if (seen_psel !== 1'b0) begin errors++; $display("FAIL de_psel: got asserted expected none"); end
        checks++; if (!got || n !== 2) begin errors++; $display("FAIL de_latency: got ok=%0d cycles=%0d expected ok=1 cycles=2", got, n); end
        checks++; if ({bus3.rsp_error, bus3.rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL de_rsp: got %b %h expected 1 00000000", bus3.rsp_error, bus3.rsp_rdata); end
        step();
    endtask

    task automatic test_queue_order;
        bit ok; bit all_ok; int n;
        logic rdy; logic rv; logic [31:0] rdv;
        logic [31:0] addrs [5];
        logic [31:0] got [6];
        logic [31:0] exp [6];
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0200; addrs[2] = 32'h0000_1300;
        addrs[3] = 32'h0000_2400; addrs[4] = 32'h0000_3500;
        exp[0] = 32'h0;
        for (int i = 0; i < 5; i++) exp[i+1] = {16'hC0DE, addrs[i][15:0]};
        auto_prdata = 1'b1; bus.rsp_ready = 1'b0; bus.PREADY = 1'b1;
        push_cmd(1'b1, 32'h0000_0040, 32'h11, 4'hF, ok);
        for (int i = 0; i < 6; i++) step();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL q_prefill: got %b expected 1", bus.rsp_valid); end
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, addrs[i], 32'h0, 4'hF, ok);
            all_ok = all_ok & ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL q_accept4: got refused expected 4 accepted"); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL q_full_ready: got %b expected 0", bus.cmd_ready); end
        bus.cmd_write = 1'b0; bus.cmd_addr = addrs[4]; bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 6; i++) begin
            rdy = bus.cmd_ready; rv = bus.rsp_valid; rdv = bus.rsp_rdata;
            step();
            if (bus.cmd_valid && rdy) bus.cmd_valid = 1'b0;
            if (rv) begin got[n] = rdv; n++; end
        end
        bus.cmd_valid = 1'b0; bus.PREADY = 1'b0;
        checks++; if (n !== 6) begin errors++; $display("FAIL q_rsp_count: got %0d expected 6", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL q_order[%0d]: got %h expected %h", i, got[i], exp[i]); end
        end
        step();
    endtask

    task automatic test_reset_mid;
        bit ok; bit reached; bit seen;
        reached = 1'b0; seen = 1'b0;
        bus.rsp_ready = 1'b1; bus.PREADY = 1'b0;
        push_cmd(1'b1, 32'h0000_0000, 32'h1, 4'hF, ok);
        push_cmd(1'b1, 32'h0000_1000, 32'h2, 4'hF, ok);
        push_cmd(1'b1, 32'h0000_2000, 32'h3, 4'hF, ok);
        for (int i = 0; i < 20; i++) begin
            if (bus.PENABLE) begin reached = 1'b1; break; end
            step();
        end
        checks++; if (!reached) begin errors++; $display("FAIL rm_access: got none expected PENABLE"); end
        #1 PRESET = 1'b1;
        #1;
        checks++; if ({bus.PSEL, bus.PENABLE} !== 5'b0) begin errors++; $display("FAIL rm_drop: got %b %b expected 0000 0", bus.PSEL, bus.PENABLE); end
        @(posedge PCLK); #1 PRESET = 1'b0;
        bus.PREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.rsp_valid || (bus.PSEL !== 4'b0)) seen = 1'b1;
        end
        bus.PREADY = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_activity: got activity expected none"); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    initial begin
        PRESET = 1'b1;
        auto_prdata = 1'b0; prdata_val = 32'h0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0;
        bus.cmd_wdata = 32'h0; bus.cmd_strb = 4'h0; bus.rsp_ready = 1'b1;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        bus3.cmd_valid = 1'b0; bus3.cmd_write = 1'b0; bus3.cmd_addr = 32'h0;
        bus3.cmd_wdata = 32'h0; bus3.cmd_strb = 4'h0; bus3.rsp_ready = 1'b1;
        bus3.PRDATA = 32'hFFFF_FFFF; bus3.PREADY = 1'b1; bus3.PSLVERR = 1'b0;
        test_reset();
        test_write_latency();
        test_read_wait();
        test_timeout();
        test_slverr();
        test_decode_err();
        test_queue_order();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
